// File: rtl/pwm_multi_adjust.sv
// Multi-channel PWM duty/period adjuster: four debounced active-low buttons with
// hold-to-repeat step the duty and period of the channel picked by Sel.
module pwm_multi_adjust #(
  parameter int CH        = 4,
  parameter int DUTY_W    = 8,
  parameter int DUTY_MAX  = 100,
  parameter int DUTY_STEP = 10,
  parameter int DUTY_INIT = 50,
  parameter int PER_W     = 24,
  parameter int PER_MIN   = 50_000,
  parameter int PER_MAX   = 500_000,
  parameter int PER_STEP  = 50_000,
  parameter int PER_INIT  = 250_000,
  parameter int DEB_CYC   = 1_000_000,
  parameter int REP_DLY   = 25_000_000,
  parameter int REP_INT   = 5_000_000,
  parameter int WRAP      = 1,
  localparam int SEL_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [SEL_W-1:0]      Sel,
  input  logic                  AddDuty_In,
  input  logic                  SubDuty_In,
  input  logic                  AddPeriod_In,
  input  logic                  SubPeriod_In,
  output logic [CH*DUTY_W-1:0]  Duty,
  output logic [CH*PER_W-1:0]   Count_P,
  output logic [CH-1:0]         Upd
);

  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int TMR_W = $clog2(((REP_DLY > REP_INT) ? REP_DLY : REP_INT) + 1);

  localparam logic [DUTY_W:0] D_MIN  = '0;
  localparam logic [DUTY_W:0] D_MAX  = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W:0] D_STEP = (DUTY_W+1)'(DUTY_STEP);
  localparam logic [PER_W:0]  P_MIN  = (PER_W+1)'(PER_MIN);
  localparam logic [PER_W:0]  P_MAX  = (PER_W+1)'(PER_MAX);
  localparam logic [PER_W:0]  P_STEP = (PER_W+1)'(PER_STEP);

  typedef enum logic [1:0] {IDLE, PRESS, REPEAT} repState_t;

  // Button order: 0 duty up, 1 duty down, 2 period up, 3 period down.
  logic [3:0] rawN;
  logic [3:0] stepEvt;

  assign rawN = {SubPeriod_In, AddPeriod_In, SubDuty_In, AddDuty_In};

  for (genvar b = 0; b < 4; b++) begin : gBtn
    logic             syncA;
    logic             syncB;
    logic             debLvl;
    logic [DEB_W-1:0] debCnt;
    repState_t        repState;
    repState_t        repNext;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmrNext;
    logic             evt;

    always_ff @(posedge CLK) begin
      if (RST) begin
        syncA  <= 1'b1;
        syncB  <= 1'b1;
        debLvl <= 1'b1;
        debCnt <= '0;
      end else begin
        syncA <= rawN[b];
        syncB <= syncA;
        if (syncB != debLvl) begin
          if (debCnt == DEB_W'(DEB_CYC - 1)) begin
            debLvl <= syncB;
            debCnt <= '0;
          end else begin
            debCnt <= debCnt + 1'b1;
          end
        end else begin
          debCnt <= '0;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        repState <= IDLE;
        tmr      <= '0;
      end else begin
        repState <= repNext;
        tmr      <= tmrNext;
      end
    end

    // A debounced release wins over any pending repeat step.
    always_comb begin
      repNext = repState;
      tmrNext = tmr;
      evt     = 1'b0;
      if (debLvl) begin
        repNext = IDLE;
        tmrNext = '0;
      end else begin
        case (repState)
          IDLE: begin
            repNext = PRESS;
            tmrNext = '0;
            evt     = 1'b1;
          end
          PRESS: begin
            if (tmr == TMR_W'(REP_DLY - 1)) begin
              repNext = REPEAT;
              tmrNext = '0;
              evt     = 1'b1;
            end else begin
              tmrNext = tmr + 1'b1;
            end
          end
          REPEAT: begin
            if (tmr == TMR_W'(REP_INT - 1)) begin
              tmrNext = '0;
              evt     = 1'b1;
            end else begin
              tmrNext = tmr + 1'b1;
            end
          end
          default: repNext = IDLE;
        endcase
      end
    end

    assign stepEvt[b] = evt;
  end

  function automatic logic [DUTY_W-1:0] stepDuty(input logic [DUTY_W-1:0] cur, input logic up);
    logic [DUTY_W:0] w;
    logic [DUTY_W:0] r;
    w = {1'b0, cur};
    if (up) begin
      if (w >= D_MAX)               r = (WRAP != 0) ? D_MIN : D_MAX;
      else if (w + D_STEP > D_MAX)  r = D_MAX;
      else                          r = w + D_STEP;
    end else begin
      if (w <= D_MIN)               r = (WRAP != 0) ? D_MAX : D_MIN;
      else if (w < D_MIN + D_STEP)  r = D_MIN;
      else                          r = w - D_STEP;
    end
    return DUTY_W'(r);
  endfunction

  function automatic logic [PER_W-1:0] stepPer(input logic [PER_W-1:0] cur, input logic up);
    logic [PER_W:0] w;
    logic [PER_W:0] r;
    w = {1'b0, cur};
    if (up) begin
      if (w >= P_MAX)               r = (WRAP != 0) ? P_MIN : P_MAX;
      else if (w + P_STEP > P_MAX)  r = P_MAX;
      else                          r = w + P_STEP;
    end else begin
      if (w <= P_MIN)               r = (WRAP != 0) ? P_MAX : P_MIN;
      else if (w < P_MIN + P_STEP)  r = P_MIN;
      else                          r = w - P_STEP;
    end
    return PER_W'(r);
  endfunction

  logic [DUTY_W-1:0] dutyR [CH];
  logic [PER_W-1:0]  perR  [CH];
  logic [CH-1:0]     updR;

  logic              selOk;
  logic [SEL_W-1:0]  selIdx;
  logic              dutyMove;
  logic              perMove;
  logic [DUTY_W-1:0] curDuty;
  logic [DUTY_W-1:0] nextDuty;
  logic [PER_W-1:0]  curPer;
  logic [PER_W-1:0]  nextPer;
  logic              dutyChg;
  logic              perChg;

  assign selOk    = (int'(Sel) < CH);
  assign selIdx   = selOk ? Sel : '0;
  // Opposing steps on the same quantity cancel.
  assign dutyMove = stepEvt[0] ^ stepEvt[1];
  assign perMove  = stepEvt[2] ^ stepEvt[3];
  assign curDuty  = dutyR[selIdx];
  assign curPer   = perR[selIdx];
  assign nextDuty = dutyMove ? stepDuty(curDuty, stepEvt[0]) : curDuty;
  assign nextPer  = perMove  ? stepPer(curPer, stepEvt[2])   : curPer;
  assign dutyChg  = selOk && dutyMove && (nextDuty != curDuty);
  assign perChg   = selOk && perMove  && (nextPer  != curPer);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < CH; k++) begin
        dutyR[k] <= DUTY_W'(DUTY_INIT);
        perR[k]  <= PER_W'(PER_INIT);
      end
      updR <= '0;
    end else begin
      updR <= '0;
      for (int k = 0; k < CH; k++) begin
        if (selIdx == SEL_W'(k)) begin
          if (dutyChg) dutyR[k] <= nextDuty;
          if (perChg)  perR[k]  <= nextPer;
          updR[k] <= dutyChg | perChg;
        end
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : gOut
    assign Duty[k*DUTY_W +: DUTY_W]  = dutyR[k];
    assign Count_P[k*PER_W +: PER_W] = perR[k];
  end

  assign Upd = updR;

endmodule

// File: tb/tb_pwm_multi_adjust.sv
// Bench for pwm_multi_adjust: a wrapping and a saturating instance share stimulus;
// each step is predicted with its exact cycle and matched against the Upd pulses.
module tb_pwm_multi_adjust;

  localparam int EW = 66;  // {cycle[31:0], chan[1:0], duty[7:0], period[23:0]}

  typedef struct {
    logic [3:0] mask;
    logic [1:0] sel;
    int         len;
    int         dW;
    int         pW;
    int         dS;
    int         pS;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic [3:0]  btnN = 4'hF;
  logic [31:0] dutyW, dutyS;
  logic [95:0] perW, perS;
  logic [3:0]  updW, updS;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] expQW[$];
  logic [EW-1:0] expQS[$];
  int mD[2][4];
  int mP[2][4];
  int lastD[2][4];
  int lastP[2][4];
  vec_t tbl[15];

  pwm_multi_adjust #(.CH(4), .DEB_CYC(4), .REP_DLY(20), .REP_INT(8), .WRAP(1)) dutW (
    .CLK(CLK), .RST(RST), .Sel(sel),
    .AddDuty_In(btnN[0]), .SubDuty_In(btnN[1]), .AddPeriod_In(btnN[2]), .SubPeriod_In(btnN[3]),
    .Duty(dutyW), .Count_P(perW), .Upd(updW)
  );

  pwm_multi_adjust #(.CH(4), .DEB_CYC(4), .REP_DLY(20), .REP_INT(8), .WRAP(0)) dutS (
    .CLK(CLK), .RST(RST), .Sel(sel),
    .AddDuty_In(btnN[0]), .SubDuty_In(btnN[1]), .AddPeriod_In(btnN[2]), .SubPeriod_In(btnN[3]),
    .Duty(dutyS), .Count_P(perS), .Upd(updS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int stepVal(input int cur, input bit up, input int mn, input int mx,
                                 input int st, input bit wrap);
    if (up) begin
      if (cur == mx) return wrap ? mn : mx;
      return (cur + st > mx) ? mx : cur + st;
    end
    if (cur == mn) return wrap ? mx : mn;
    return (cur - st < mn) ? mn : cur - st;
  endfunction

  task automatic modelReset();
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 4; k++) begin
        mD[w][k] = 50;
        mP[w][k] = 250000;
      end
  endtask

  // One step event on the buttons in mask at the given cycle, for both instances.
  task automatic modelEvent(input logic [3:0] mask, input logic [1:0] s, input int stamp);
    int nd, np;
    logic [EW-1:0] e;
    for (int w = 0; w < 2; w++) begin
      nd = mD[w][s];
      np = mP[w][s];
      if (mask[0] != mask[1]) nd = stepVal(nd, mask[0], 0, 100, 10, w == 0);
      if (mask[2] != mask[3]) np = stepVal(np, mask[2], 50000, 500000, 50000, w == 0);
      if (nd != mD[w][s] || np != mP[w][s]) begin
        mD[w][s] = nd;
        mP[w][s] = np;
        e = {32'(stamp), s, 8'(nd), 24'(np)};
        if (w == 0) expQW.push_back(e);
        else        expQS.push_back(e);
      end
    end
  endtask

  // Hold buttons low for len cycles; steps land 6, 26, 34, ... edges after the first
  // sampled low level, and none once the debounced release is seen.
  task automatic hold(input logic [3:0] mask, input logic [1:0] s, input int len);
    int c0;
    int k;
    @(negedge CLK);
    sel  = s;
    btnN = ~mask;
    c0   = cyc;
    if (len >= 4) begin
      k = 6;
      while (k <= len + 5) begin
        modelEvent(mask, s, c0 + 1 + k);
        k += (k == 6) ? 20 : 8;
      end
    end
    repeat (len) @(negedge CLK);
    btnN = 4'hF;
    repeat (12) @(negedge CLK);
  endtask

  task automatic checkInit();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("init_duty_W%0d", k), int'(dutyW[k*8 +: 8]), 50);
      chk($sformatf("init_per_W%0d", k), int'(perW[k*24 +: 24]), 250000);
      chk($sformatf("init_duty_S%0d", k), int'(dutyS[k*8 +: 8]), 50);
      chk($sformatf("init_per_S%0d", k), int'(perS[k*24 +: 24]), 250000);
    end
    chk("init_upd_W", int'(updW), 0);
    chk("init_upd_S", int'(updS), 0);
  endtask

  task automatic monDut(input int w, input logic [31:0] d, input logic [95:0] p, input logic [3:0] u);
    int curD, curP;
    logic have;
    logic [EW-1:0] e;
    string tag;
    tag = (w == 0) ? "W" : "S";
    for (int k = 0; k < 4; k++) begin
      curD = int'(d[k*8 +: 8]);
      curP = int'(p[k*24 +: 24]);
      if (!RST) begin
        if (u[k]) begin
          have = 1'b0;
          e = '0;
          if (w == 0 && expQW.size() > 0) begin have = 1'b1; e = expQW.pop_front(); end
          if (w == 1 && expQS.size() > 0) begin have = 1'b1; e = expQS.pop_front(); end
          if (!have) begin
            checks++;
            failures++;
            $display("FAIL upd_unexpected_%s chan=%0d actual=1 required=0 (cycle %0d)", tag, k, cyc);
          end else begin
            chk({"upd_cycle_", tag}, cyc, int'(e[65:34]));
            chk({"upd_chan_", tag}, k, int'(e[33:32]));
            chk({"upd_duty_", tag}, curD, int'(e[31:24]));
            chk({"upd_per_", tag}, curP, int'(e[23:0]));
          end
        end else begin
          checks++;
          if (curD != lastD[w][k] || curP != lastP[w][k]) begin
            failures++;
            $display("FAIL silent_change_%s chan=%0d actual=%0d/%0d required=%0d/%0d (cycle %0d)",
                     tag, k, curD, curP, lastD[w][k], lastP[w][k], cyc);
          end
        end
      end
      lastD[w][k] = curD;
      lastP[w][k] = curP;
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      monDut(0, dutyW, perW, updW);
      monDut(1, dutyS, perS, updS);
    end
  end

  initial begin
    int c0;
    // mask bits: 0 duty up, 1 duty down, 2 period up, 3 period down
    tbl[0]  = '{4'b0001, 2'd2,  3,  50, 250000,  50, 250000};
    tbl[1]  = '{4'b0001, 2'd2, 10,  60, 250000,  60, 250000};
    tbl[2]  = '{4'b0001, 2'd0, 60,   0, 250000, 100, 250000};
    tbl[3]  = '{4'b1000, 2'd1, 10,  50, 200000,  50, 200000};
    tbl[4]  = '{4'b1000, 2'd1, 10,  50, 150000,  50, 150000};
    tbl[5]  = '{4'b1000, 2'd1, 10,  50, 100000,  50, 100000};
    tbl[6]  = '{4'b1000, 2'd1, 10,  50,  50000,  50,  50000};
    tbl[7]  = '{4'b1000, 2'd1, 10,  50, 500000,  50,  50000};
    tbl[8]  = '{4'b1000, 2'd1, 10,  50, 450000,  50,  50000};
    tbl[9]  = '{4'b0011, 2'd3, 10,  50, 250000,  50, 250000};
    tbl[10] = '{4'b0101, 2'd3, 10,  60, 300000,  60, 300000};
    tbl[11] = '{4'b0010, 2'd0, 10, 100, 250000,  90, 250000};
    tbl[12] = '{4'b0100, 2'd1, 10,  50, 500000,  50, 100000};
    tbl[13] = '{4'b0100, 2'd1, 10,  50,  50000,  50, 150000};
    tbl[14] = '{4'b0010, 2'd2, 28,  40, 250000,  40, 250000};

    RST  = 1'b1;
    btnN = 4'hF;
    repeat (3) @(negedge CLK);
    checkInit();
    RST = 1'b0;
    modelReset();

    for (int i = 0; i < 15; i++) begin
      hold(tbl[i].mask, tbl[i].sel, tbl[i].len);
      chk($sformatf("vec%0d_duty_W", i), int'(dutyW[tbl[i].sel*8 +: 8]), tbl[i].dW);
      chk($sformatf("vec%0d_per_W", i), int'(perW[tbl[i].sel*24 +: 24]), tbl[i].pW);
      chk($sformatf("vec%0d_duty_S", i), int'(dutyS[tbl[i].sel*8 +: 8]), tbl[i].dS);
      chk($sformatf("vec%0d_per_S", i), int'(perS[tbl[i].sel*24 +: 24]), tbl[i].pS);
    end

    // Reset in the middle of auto-repeat, then a fresh single press.
    @(negedge CLK);
    sel  = 2'd2;
    btnN = ~4'b0001;
    c0   = cyc;
    modelEvent(4'b0001, 2'd2, c0 + 7);
    modelEvent(4'b0001, 2'd2, c0 + 27);
    modelEvent(4'b0001, 2'd2, c0 + 35);
    repeat (40) @(negedge CLK);
    RST  = 1'b1;
    btnN = 4'hF;
    @(negedge CLK);
    checkInit();
    RST = 1'b0;
    modelReset();
    chk("prereset_steps_left_W", expQW.size(), 0);
    chk("prereset_steps_left_S", expQS.size(), 0);
    expQW.delete();
    expQS.delete();
    repeat (10) @(negedge CLK);
    hold(4'b0001, 2'd2, 10);
    chk("repress_duty_W", int'(dutyW[2*8 +: 8]), 60);
    chk("repress_duty_S", int'(dutyS[2*8 +: 8]), 60);
    chk("repress_other_W", int'(dutyW[0 +: 8]), 50);

    repeat (5) @(negedge CLK);
    chk("steps_left_W", expQW.size(), 0);
    chk("steps_left_S", expQS.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
